// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory sequencer with req/ack handshake, lane formatting and error aborts.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DMWr_me,
  input  logic [1:0]  RUDataWrSrc_me,
  input  logic [2:0]  DMCtrl_me,
  input  logic [31:0] ALURes_me,
  input  logic [31:0] RUrs2_me,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic [31:0] DMDataRd_me,
  output logic        stall_o,
  output logic        access_err_o,
  output logic        timeout_err_o
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic [1:0] lane_q, lane_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d, tout_q, tout_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, rd_q, rd_d;
  logic [3:0] mem_be_q, mem_be_d;
  logic acc, misal, illegal, legal, tmo;
  logic [3:0] be;
  logic [31:0] wdata, byte_sh, ld_fmt;
  logic [15:0] half_sel;
  always_comb begin
    acc = DMWr_me | (RUDataWrSrc_me == 2'b01);
    misal = (DMCtrl_me[1:0] == 2'b01 & ALURes_me[0]) | (DMCtrl_me[1:0] == 2'b10 & ALURes_me[1:0] != 2'b00);
    illegal = DMCtrl_me == 3'b011 | DMCtrl_me[2:1] == 2'b11 | (DMWr_me & DMCtrl_me[2]);
    legal = ~misal & ~illegal;
    be = DMCtrl_me[1] ? 4'b1111 : DMCtrl_me[0] ? (ALURes_me[1] ? 4'b1100 : 4'b0011) : 4'b0001 << ALURes_me[1:0];
    wdata = DMCtrl_me[1] ? RUrs2_me : DMCtrl_me[0] ? {2{RUrs2_me[15:0]}} : {4{RUrs2_me[7:0]}};
    byte_sh = mem_rdata >> {lane_q, 3'b000};
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_fmt = ctrl_q[1] ? mem_rdata
           : ctrl_q[0] ? {ctrl_q[2] ? 16'h0 : {16{half_sel[15]}}, half_sel}
           : {ctrl_q[2] ? 24'h0 : {24{byte_sh[7]}}, byte_sh[7:0]};
    tmo = cnt_q == 16'(TIMEOUT_CYCLES - 1);
    state_d = state_q;
    cnt_d = cnt_q;
    ctrl_d = ctrl_q;
    lane_d = lane_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_be_d = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rd_d = rd_q;
    tout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc & legal) begin
          state_d = WAIT;
          mem_req_d = 1'b1;
          mem_we_d = DMWr_me;
          mem_addr_d = {ALURes_me[31:2], 2'b00};
          mem_be_d = be;
          mem_wdata_d = wdata;
          ctrl_d = DMCtrl_me;
          lane_d = ALURes_me[1:0];
          cnt_d = 16'd0;
        end else if (acc) rd_d = 32'h0;
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_ack | tmo) begin
          state_d = DONE;
          mem_req_d = 1'b0;
          mem_we_d = 1'b0;
          mem_be_d = 4'b0000;
          // an ack in the final timeout cycle still completes normally
          rd_d = mem_ack ? (mem_we_q ? rd_q : ld_fmt) : 32'h0;
          tout_d = ~mem_ack;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ctrl_q <= '0;
      lane_q <= '0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_be_q <= '0;
      mem_wdata_q <= '0;
      rd_q <= '0;
      tout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ctrl_q <= ctrl_d;
      lane_q <= lane_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_be_q <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rd_q <= rd_d;
      tout_q <= tout_d;
    end
  end
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_be = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign DMDataRd_me = rd_q;
  assign timeout_err_o = tout_q;
  assign stall_o = acc & legal & (state_q != DONE);
  assign access_err_o = acc & ~legal;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: table-driven transactions plus reset, timeout and late-ack sequences.
module tb_dmem_access_ctrl;
  logic clk, rst, rst_t;
  logic wr;
  logic [1:0] src;
  logic [2:0] ctrl;
  logic [31:0] addr, rs2, rdata;
  logic ack;
  logic req, we, stall, err, tout;
  logic [31:0] maddr, wdata, rd;
  logic [3:0] be;
  logic t_req, t_we, t_stall, t_err, t_tout;
  logic [31:0] t_maddr, t_wdata, t_rd;
  logic [3:0] t_be;
  int tests = 0, fails = 0;
  dmem_access_ctrl dut (
    .clk(clk), .rst(rst), .DMWr_me(wr), .RUDataWrSrc_me(src), .DMCtrl_me(ctrl),
    .ALURes_me(addr), .RUrs2_me(rs2), .mem_ack(ack), .mem_rdata(rdata),
    .mem_req(req), .mem_we(we), .mem_addr(maddr), .mem_be(be), .mem_wdata(wdata),
    .DMDataRd_me(rd), .stall_o(stall), .access_err_o(err), .timeout_err_o(tout)
  );
  dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk(clk), .rst(rst_t), .DMWr_me(wr), .RUDataWrSrc_me(src), .DMCtrl_me(ctrl),
    .ALURes_me(addr), .RUrs2_me(rs2), .mem_ack(ack), .mem_rdata(rdata),
    .mem_req(t_req), .mem_we(t_we), .mem_addr(t_maddr), .mem_be(t_be), .mem_wdata(t_wdata),
    .DMDataRd_me(t_rd), .stall_o(t_stall), .access_err_o(t_err), .timeout_err_o(t_tout)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {
    logic wr; logic [1:0] src; logic [2:0] ctrl;
    logic [31:0] addr, rs2, rdata; int ack_dly; logic err;
    logic [3:0] be; logic [31:0] wdata, rd;
  } vec_t;
  vec_t v[17];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wr = 0; src = 0; ctrl = 0; addr = 0; rs2 = 0;
  endtask
  task automatic drive(input logic w, input logic [1:0] s, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    wr = w; src = s; ctrl = c; addr = a; rs2 = d;
  endtask
  task automatic run_vec(input int i);
    int sc, rc;
    step();
    drive(v[i].wr, v[i].src, v[i].ctrl, v[i].addr, v[i].rs2);
    ack = 0; rdata = v[i].rdata;
    @(negedge clk);
    chk($sformatf("v%0d stall0", i), stall, !v[i].err);
    chk($sformatf("v%0d access_err", i), err, v[i].err);
    sc = stall; rc = 0;
    if (v[i].err) begin
      step();
      idle();
      @(negedge clk);
      chk($sformatf("v%0d err rd", i), rd, 0);
      chk($sformatf("v%0d err req", i), req, 0);
    end else begin
      for (int c = 1; c <= v[i].ack_dly + 1; c++) begin
        step();
        ack = (c == v[i].ack_dly);
        @(negedge clk);
        sc += stall; rc += req;
        if (c == 1) begin
          chk($sformatf("v%0d be", i), be, v[i].be);
          chk($sformatf("v%0d we", i), we, v[i].wr);
          chk($sformatf("v%0d addr", i), maddr, {v[i].addr[31:2], 2'b00});
          if (v[i].wr) chk($sformatf("v%0d wdata", i), wdata, v[i].wdata);
        end
      end
      chk($sformatf("v%0d rd", i), rd, v[i].rd);
      chk($sformatf("v%0d done req", i), req, 0);
      chk($sformatf("v%0d stall cycles", i), sc, v[i].ack_dly + 1);
      chk($sformatf("v%0d req cycles", i), rc, v[i].ack_dly);
      step();
      idle();
      ack = 0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int rq, tc, tcyc;
    v[0]  = '{1, 2'b00, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1, 0, 4'b1111, 32'hDEADBEEF, 32'h0};
    v[1]  = '{0, 2'b01, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1, 0, 4'b1111, 32'h0, 32'hDEADBEEF};
    v[2]  = '{0, 2'b01, 3'b000, 32'h203, 32'h0,        32'h80FF7F01, 2, 0, 4'b1000, 32'h0, 32'hFFFFFF80};
    v[3]  = '{0, 2'b01, 3'b100, 32'h203, 32'h0,        32'h80FF7F01, 1, 0, 4'b1000, 32'h0, 32'h00000080};
    v[4]  = '{1, 2'b00, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        5, 0, 4'b1100, 32'hABCDABCD, 32'h00000080};
    v[5]  = '{0, 2'b01, 3'b001, 32'h102, 32'h0,        32'h80FF7F01, 3, 0, 4'b1100, 32'h0, 32'hFFFF80FF};
    v[6]  = '{0, 2'b01, 3'b101, 32'h000, 32'h0,        32'h80FF7F01, 1, 0, 4'b0011, 32'h0, 32'h00007F01};
    v[7]  = '{1, 2'b00, 3'b000, 32'h001, 32'h000000A5, 32'h0,        2, 0, 4'b0010, 32'hA5A5A5A5, 32'h00007F01};
    v[8]  = '{0, 2'b01, 3'b010, 32'h101, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0, 32'h0};
    v[9]  = '{0, 2'b01, 3'b000, 32'h200, 32'h0,        32'h0000007F, 1, 0, 4'b0001, 32'h0, 32'h0000007F};
    v[10] = '{0, 2'b01, 3'b001, 32'h003, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0, 32'h0};
    v[11] = '{0, 2'b01, 3'b010, 32'h104, 32'h0,        32'h12345678, 4, 0, 4'b1111, 32'h0, 32'h12345678};
    v[12] = '{1, 2'b00, 3'b100, 32'h100, 32'h55,       32'h0,        0, 1, 4'b0000, 32'h0, 32'h0};
    v[13] = '{0, 2'b01, 3'b000, 32'h001, 32'h0,        32'h00008000, 1, 0, 4'b0010, 32'h0, 32'hFFFFFF80};
    v[14] = '{0, 2'b01, 3'b011, 32'h000, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0, 32'h0};
    v[15] = '{0, 2'b01, 3'b100, 32'h002, 32'h0,        32'h00AB0000, 1, 0, 4'b0100, 32'h0, 32'h000000AB};
    v[16] = '{1, 2'b00, 3'b010, 32'h008, 32'hCAFEBABE, 32'h0,        3, 0, 4'b1111, 32'hCAFEBABE, 32'h000000AB};
    idle(); ack = 0; rdata = 0; rst = 1; rst_t = 1;
    step(); step();
    rst = 0;
    @(negedge clk);
    chk("reset req", req, 0);
    chk("reset we", we, 0);
    chk("reset addr", maddr, 0);
    chk("reset be", be, 0);
    chk("reset wdata", wdata, 0);
    chk("reset rd", rd, 0);
    chk("reset tout", tout, 0);
    chk("reset stall", stall, 0);
    for (int i = 0; i < 17; i++) run_vec(i);
    // non-memory instruction with a misaligned-looking ALU result
    step();
    drive(0, 2'b10, 3'b010, 32'h101, 32'h0);
    @(negedge clk);
    chk("nonmem stall", stall, 0);
    chk("nonmem err", err, 0);
    step();
    idle();
    @(negedge clk);
    chk("nonmem req", req, 0);
    chk("nonmem rd kept", rd, 32'hAB);
    // reset in the second WAIT cycle, then a late ack
    step();
    drive(0, 2'b01, 3'b010, 32'h100, 32'h0);
    step();
    step();
    rst = 1;
    @(negedge clk);
    chk("rst-wait req before", req, 1);
    step();
    rst = 0; idle(); ack = 1; rdata = 32'h55555555;
    @(negedge clk);
    chk("rst-wait req", req, 0);
    chk("rst-wait we", we, 0);
    chk("rst-wait addr", maddr, 0);
    chk("rst-wait be", be, 0);
    chk("rst-wait rd", rd, 0);
    chk("rst-wait tout", tout, 0);
    chk("rst-wait stall", stall, 0);
    step();
    ack = 0;
    @(negedge clk);
    chk("late ack rd", rd, 0);
    chk("late ack req", req, 0);
    // timeout sequences on the TIMEOUT_CYCLES=4 instance
    rst = 1; rst_t = 0;
    step();
    drive(0, 2'b01, 3'b010, 32'h100, 32'h0);
    rdata = 32'h11223344;
    for (int c = 1; c <= 3; c++) begin
      step();
      ack = (c == 2);
      @(negedge clk);
    end
    chk("t prime rd", t_rd, 32'h11223344);
    step();
    idle(); ack = 0;
    step();
    drive(0, 2'b01, 3'b010, 32'h104, 32'h0);
    @(negedge clk);
    chk("t stall0", t_stall, 1);
    rq = 0; tc = 0; tcyc = -1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 6) idle();
      @(negedge clk);
      rq += t_req;
      if (t_tout) begin tc++; tcyc = c; end
      if (c == 5) begin
        chk("t timeout rd", t_rd, 0);
        chk("t timeout stall", t_stall, 0);
      end
    end
    chk("t req cycles", rq, 4);
    chk("t pulse count", tc, 1);
    chk("t pulse cycle", tcyc, 5);
    step();
    drive(0, 2'b01, 3'b010, 32'h108, 32'h0);
    rdata = 32'hCAFEF00D;
    rq = 0; tc = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      ack = (c == 4);
      if (c == 6) idle();
      @(negedge clk);
      rq += t_req; tc += t_tout;
      if (c == 5) begin
        chk("t ack-last rd", t_rd, 32'hCAFEF00D);
        chk("t ack-last stall", t_stall, 0);
      end
    end
    chk("t ack-last req cycles", rq, 4);
    chk("t ack-last no error", tc, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
